// File: rtl/sga_render_pkg.sv
// Shared definitions for the snake matrix renderer: FSM state codes and width helpers.
// The state codes double as the db_state values shown on the 7-segment debug display.
package sga_render_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_READ    = 3'd2,
        ST_APPLE   = 3'd3,
        ST_PUBLISH = 3'd4
    } render_state_t;

    // Clamped to 1 so that degenerate sizes still produce a legal vector.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

    function automatic int led_count(input int rows, input int cols);
        return rows * cols;
    endfunction

    function automatic int pos_w(input int rows, input int cols);
        return clog2_min1(rows * cols);
    endfunction

    function automatic int addr_w(input int max_size);
        return clog2_min1(max_size);
    endfunction

    function automatic int size_w(input int max_size);
        return clog2_min1(max_size + 1);
    endfunction

endpackage

// File: rtl/snake_pos_decoder.sv
// Combinational linear-index to one-hot LED decoder; indices outside the matrix
// decode to all zeros and raise oob.
module snake_pos_decoder #(
    parameter int NUM_LEDS = 36,
    parameter int POS_W    = 6
) (
    input  logic [POS_W-1:0]    idx,
    output logic [NUM_LEDS-1:0] onehot,
    output logic                oob
);

    always_comb begin
        onehot = '0;
        oob    = (32'(idx) >= NUM_LEDS);
        for (int i = 0; i < NUM_LEDS; i++) begin
            onehot[i] = (32'(idx) == i);
        end
    end

endmodule

// File: rtl/snake_matrix_renderer.sv
// Snake frame renderer: walks body RAM into a shadow frame, adds the apple, publishes atomically.
// Define APPLE_BLINK_EN to blink the apple every BLINK_DIV published frames.
module snake_matrix_renderer
    import sga_render_pkg::*;
#(
    parameter int ROWS      = 6,
    parameter int COLS      = 6,
    parameter int MAX_SIZE  = 16,
    parameter int BLINK_DIV = 4
) (
    input  logic                               clock,
    input  logic                               restart,
    input  logic                               start,
    input  logic [size_w(MAX_SIZE)-1:0]        size,
    output logic [addr_w(MAX_SIZE)-1:0]        rd_addr,
    input  logic [pos_w(ROWS, COLS)-1:0]       rd_data,
    input  logic [pos_w(ROWS, COLS)-1:0]       apple_pos,
    input  logic                               apple_vld,
    input  logic                               blank,
    output logic                               busy,
    output logic                               done,
    output logic [led_count(ROWS, COLS)-1:0]   leds,
    output logic                               err_oob,
    output logic [2:0]                         db_state
);

    localparam int NUM_LEDS = led_count(ROWS, COLS);
    localparam int POS_W    = pos_w(ROWS, COLS);
    localparam int ADDR_W   = addr_w(MAX_SIZE);
    localparam int SIZE_W   = size_w(MAX_SIZE);

    render_state_t state, next_state;

    logic [SIZE_W-1:0]   n_q;
    logic [SIZE_W-1:0]   paint_cnt;
    logic [SIZE_W-1:0]   n_clamped;
    logic [NUM_LEDS-1:0] shadow;
    logic [NUM_LEDS-1:0] seg_onehot;
    logic [NUM_LEDS-1:0] apple_onehot;
    logic                seg_oob;
    logic                apple_oob;
    logic                apple_show;

    assign n_clamped = (32'(size) > MAX_SIZE) ? SIZE_W'(MAX_SIZE) : size;
    assign busy      = (state != ST_IDLE);
    assign db_state  = state;

    snake_pos_decoder #(
        .NUM_LEDS (NUM_LEDS),
        .POS_W    (POS_W)
    ) u_seg_decoder (
        .idx    (rd_data),
        .onehot (seg_onehot),
        .oob    (seg_oob)
    );

    snake_pos_decoder #(
        .NUM_LEDS (NUM_LEDS),
        .POS_W    (POS_W)
    ) u_apple_decoder (
        .idx    (apple_pos),
        .onehot (apple_onehot),
        .oob    (apple_oob)
    );

`ifdef APPLE_BLINK_EN
    localparam int BLINK_W = clog2_min1(2 * BLINK_DIV);

    logic [BLINK_W-1:0] blink_cnt;

    // Counts published frames modulo 2*BLINK_DIV; first half of the period shows the apple.
    always_ff @(posedge clock) begin
        if (restart) begin
            blink_cnt <= '0;
        end else if (state == ST_PUBLISH) begin
            if (32'(blink_cnt) == 2 * BLINK_DIV - 1) begin
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    assign apple_show = apple_vld && (32'(blink_cnt) < BLINK_DIV);
`else
    // Without blinking the apple is always shown; a zero divider hides it entirely.
    assign apple_show = apple_vld && (BLINK_DIV > 0);
`endif

    always_ff @(posedge clock) begin
        if (restart) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                next_state = (n_q != '0) ? ST_READ : ST_APPLE;
            end
            ST_READ: begin
                if (paint_cnt == n_q - SIZE_W'(1)) begin
                    next_state = ST_APPLE;
                end
            end
            ST_APPLE:   next_state = ST_PUBLISH;
            ST_PUBLISH: next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Address 0 is presented during CLEAR so the first READ cycle already has its data;
    // from then on each READ cycle paints the entry fetched for the previous address.
    always_ff @(posedge clock) begin
        if (restart) begin
            n_q       <= '0;
            paint_cnt <= '0;
            shadow    <= '0;
            leds      <= '0;
            done      <= 1'b0;
            err_oob   <= 1'b0;
            rd_addr   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_q     <= n_clamped;
                        rd_addr <= '0;
                    end
                end
                ST_CLEAR: begin
                    shadow    <= '0;
                    paint_cnt <= '0;
                    rd_addr   <= ADDR_W'(1);
                end
                ST_READ: begin
                    shadow    <= shadow | seg_onehot;
                    paint_cnt <= paint_cnt + SIZE_W'(1);
                    rd_addr   <= rd_addr + ADDR_W'(1);
                    if (seg_oob) begin
                        err_oob <= 1'b1;
                    end
                end
                ST_APPLE: begin
                    if (apple_show) begin
                        shadow <= shadow | apple_onehot;
                    end
                    if (apple_vld && apple_oob) begin
                        err_oob <= 1'b1;
                    end
                end
                ST_PUBLISH: begin
                    leds    <= blank ? '0 : shadow;
                    done    <= 1'b1;
                    rd_addr <= '0;
                end
                default: begin
                    n_q <= n_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_matrix_renderer.sv
// Self-checking bench for snake_matrix_renderer (6x6, 16 segments) with a registered body RAM model.
module tb_snake_matrix_renderer;

    localparam int ROWS      = 6;
    localparam int COLS      = 6;
    localparam int MAX_SIZE  = 16;
    localparam int BLINK_DIV = 4;
    localparam int NL        = ROWS * COLS;

    logic        clock = 1'b0;
    logic        restart;
    logic        start;
    logic [4:0]  size;
    logic [3:0]  rd_addr;
    logic [5:0]  rd_data;
    logic [5:0]  apple_pos;
    logic        apple_vld;
    logic        blank;
    logic        busy;
    logic        done;
    logic [35:0] leds;
    logic        err_oob;
    logic [2:0]  db_state;

    int   total = 0;
    int   bad   = 0;
    int   frames = 0;
    logic exp_err = 1'b0;

    logic [5:0] ram [MAX_SIZE];

    snake_matrix_renderer #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .MAX_SIZE  (MAX_SIZE),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clock     (clock),
        .restart   (restart),
        .start     (start),
        .size      (size),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .apple_pos (apple_pos),
        .apple_vld (apple_vld),
        .blank     (blank),
        .busy      (busy),
        .done      (done),
        .leds      (leds),
        .err_oob   (err_oob),
        .db_state  (db_state)
    );

    always #5 clock = ~clock;

    // Body RAM: data for an address appears one clock after it is presented.
    always @(posedge clock) rd_data <= ram[rd_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp_n(input int n_req);
        return (n_req > MAX_SIZE) ? MAX_SIZE : n_req;
    endfunction

    // Expected picture: every drawn segment and the visible apple lit, or nothing when blanked.
    function automatic logic [35:0] model_frame(input int n_req, input int ap, input logic av,
                                                input logic bl, input int frame_idx);
        logic [35:0] f;
        logic        show;
        f = '0;
        for (int i = 0; i < clamp_n(n_req); i++) begin
            if (int'(ram[i]) < NL) f[ram[i]] = 1'b1;
        end
        show = av;
`ifdef APPLE_BLINK_EN
        show = av && (((frame_idx / BLINK_DIV) % 2) == 0);
`else
        if (frame_idx < 0) show = 1'b0;
`endif
        if (show && ap < NL) f[ap] = 1'b1;
        if (bl) f = '0;
        return f;
    endfunction

    function automatic logic model_err(input int n_req, input int ap, input logic av);
        logic e;
        e = av && (ap >= NL);
        for (int i = 0; i < clamp_n(n_req); i++) begin
            if (int'(ram[i]) >= NL) e = 1'b1;
        end
        return e;
    endfunction

    task automatic do_restart();
        @(negedge clock);
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        frames  = 0;
        exp_err = 1'b0;
    endtask

    // Runs one render from a negedge in IDLE; observation j is taken after the j-th edge past start.
    task automatic run_render(input int n_req, input int ap, input logic av, input logic bl,
                              input logic retrig, input string tag);
        logic [35:0] exp_f;
        logic [35:0] prev;
        int          lat;
        int          busy_cnt;
        logic        held;
        int          n;
        n        = clamp_n(n_req);
        exp_f    = model_frame(n_req, ap, av, bl, frames);
        exp_err  = exp_err | model_err(n_req, ap, av);
        prev     = leds;
        lat      = -1;
        busy_cnt = 0;
        held     = 1'b1;
        start     = 1'b1;
        size      = 5'(n_req);
        apple_pos = 6'(ap);
        apple_vld = av;
        blank     = bl;
        @(negedge clock);
        start = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (done) begin
                lat = j;
                break;
            end
            if (busy) busy_cnt++;
            if (leds !== prev) held = 1'b0;
            start = (retrig && j == 1);
            @(negedge clock);
        end
        start = 1'b0;
        frames++;
        chk({tag, "_latency"}, 64'(lat), 64'(n + 3));
        chk({tag, "_leds"}, 64'(leds), 64'(exp_f));
        chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(n + 3));
        chk({tag, "_leds_held"}, 64'(held), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, "_err_oob"}, 64'(err_oob), 64'(exp_err));
        @(negedge clock);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int done_seen;
        restart   = 1'b1;
        start     = 1'b0;
        size      = '0;
        apple_pos = '0;
        apple_vld = 1'b0;
        blank     = 1'b0;
        for (int i = 0; i < MAX_SIZE; i++) ram[i] = '0;
        repeat (2) @(negedge clock);
        restart = 1'b0;

        chk("reset_leds", 64'(leds), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_err", 64'(err_oob), 64'd0);
        chk("reset_rd_addr", 64'(rd_addr), 64'd0);
        chk("reset_state", 64'(db_state), 64'd0);

        ram[0] = 6'd0; ram[1] = 6'd1; ram[2] = 6'd2;
        run_render(3, 35, 1'b1, 1'b0, 1'b0, "three_seg_apple");
        chk("three_seg_frame_const", 64'(leds), 64'h8_0000_0007);

        // Abort a render of five segments while the body is being read.
        for (int i = 0; i < 5; i++) ram[i] = 6'(10 + i);
        start = 1'b1;
        size  = 5'd5;
        @(negedge clock);
        start = 1'b0;
        repeat (2) @(negedge clock);
        chk("abort_in_read", 64'(db_state), 64'd2);
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        frames  = 0;
        exp_err = 1'b0;
        chk("abort_leds", 64'(leds), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        done_seen = 0;
        repeat (20) begin
            @(negedge clock);
            if (done) done_seen++;
        end
        chk("abort_no_done", 64'(done_seen), 64'd0);

        run_render(0, 0, 1'b0, 1'b0, 1'b1, "empty_retrig");
        chk("empty_frame_const", 64'(leds), 64'd0);
        done_seen = 0;
        repeat (8) begin
            @(negedge clock);
            if (done || busy) done_seen++;
        end
        chk("retrig_ignored", 64'(done_seen), 64'd0);

        for (int i = 0; i < MAX_SIZE; i++) ram[i] = 6'(i);
        run_render(20, 0, 1'b0, 1'b0, 1'b0, "clamp_size");
        chk("clamp_frame_const", 64'(leds), 64'h0_0000_FFFF);

        ram[0] = 6'd36;
        run_render(1, 0, 1'b0, 1'b0, 1'b0, "oob_seg");
        chk("oob_sticky_const", 64'(err_oob), 64'd1);
        for (int i = 0; i < MAX_SIZE; i++) ram[i] = 6'(i);
        run_render(3, 20, 1'b1, 1'b1, 1'b0, "blank_run");

        do_restart();
        chk("restart_clears_err", 64'(err_oob), 64'd0);
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < MAX_SIZE; i++) ram[i] = 6'($urandom_range(0, 40));
            run_render($urandom_range(0, 20), $urandom_range(0, 39), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 5) == 0), 1'b0, $sformatf("rand%0d", k));
        end

        do_restart();
        for (int k = 0; k < 2 * BLINK_DIV; k++) begin
            run_render(0, 7, 1'b1, 1'b0, 1'b0, $sformatf("apple_frame%0d", k + 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
